// File: rtl/sha_phase_scheduler.sv
// Phase sequencer for the parallel SHA-256 core bank of the miner.
// Runs the phase-1 midstate once, then phase-2/phase-3 batches over the nonce space.
module sha_phase_scheduler #(
  parameter int NUM_CORES  = 16,
  parameter int NUM_NONCES = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [NUM_CORES-1:0] core_start,
  output logic [1:0]           phase,
  output logic [15:0]          nonce_base,
  output logic                 hin_sel,
  output logic                 mid_capture,
  output logic                 result_we,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_ONE = WDW'(1);
  localparam logic [16:0] STEP = 17'(NUM_CORES);
  localparam logic [16:0] LIMIT = 17'(NUM_NONCES);
  localparam logic [NUM_CORES-1:0] ALL = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1_GO,
    S_P1_WAIT,
    S_P2_GO,
    S_P2_WAIT,
    S_P3_GO,
    S_P3_WAIT,
    S_FIN
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] collect_q, collect_d;
  logic [WDW-1:0]       wdog_q, wdog_d;
  logic [15:0]          nb_q, nb_d;
  logic                 err_q, err_d;

  logic [NUM_CORES-1:0] seen;
  logic                 all_in;
  logic                 wd_exp;
  logic [16:0]          nb_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      collect_q <= '0;
      wdog_q    <= '0;
      nb_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      collect_q <= collect_d;
      wdog_q    <= wdog_d;
      nb_q      <= nb_d;
      err_q     <= err_d;
    end
  end

  // A pulse landing with the last missing bit still completes the phase.
  assign seen    = collect_q | core_done;
  assign all_in  = (seen == ALL);
  assign wd_exp  = (wdog_q == WD_LAST);
  assign nb_next = {1'b0, nb_q} + STEP;

  always_comb begin
    state_d     = state_q;
    collect_d   = collect_q;
    wdog_d      = wdog_q;
    nb_d        = nb_q;
    err_d       = err_q;
    core_start  = '0;
    phase       = 2'd0;
    hin_sel     = 1'b0;
    mid_capture = 1'b0;
    result_we   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        wdog_d    = '0;
        collect_d = '0;
        if (start) begin
          state_d = S_P1_GO;
          err_d   = 1'b0;
          nb_d    = '0;
        end
      end
      S_P1_GO: begin
        phase         = 2'd1;
        core_start[0] = 1'b1;
        wdog_d        = '0;
        state_d       = S_P1_WAIT;
      end
      S_P1_WAIT: begin
        phase  = 2'd1;
        wdog_d = wdog_q + WD_ONE;
        if (core_done[0]) begin
          mid_capture = 1'b1;
          state_d     = S_P2_GO;
        end else if (wd_exp) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_P2_GO: begin
        phase      = 2'd2;
        hin_sel    = 1'b1;
        core_start = ALL;
        wdog_d     = '0;
        collect_d  = '0;
        state_d    = S_P2_WAIT;
      end
      S_P2_WAIT: begin
        phase     = 2'd2;
        hin_sel   = 1'b1;
        wdog_d    = wdog_q + WD_ONE;
        collect_d = seen;
        if (all_in) begin
          collect_d = '0;
          state_d   = S_P3_GO;
        end else if (wd_exp) begin
          collect_d = '0;
          err_d     = 1'b1;
          state_d   = S_FIN;
        end
      end
      S_P3_GO: begin
        phase      = 2'd3;
        core_start = ALL;
        wdog_d     = '0;
        collect_d  = '0;
        state_d    = S_P3_WAIT;
      end
      S_P3_WAIT: begin
        phase     = 2'd3;
        wdog_d    = wdog_q + WD_ONE;
        collect_d = seen;
        if (all_in) begin
          collect_d = '0;
          result_we = 1'b1;
          // Phase 1 midstate is reused; only P2/P3 repeat per batch.
          if (nb_next < LIMIT) begin
            nb_d    = nb_next[15:0];
            state_d = S_P2_GO;
          end else begin
            state_d = S_FIN;
          end
        end else if (wd_exp) begin
          collect_d = '0;
          err_d     = 1'b1;
          state_d   = S_FIN;
        end
      end
      S_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign nonce_base = nb_q;
  assign error      = err_q;

endmodule

// File: tb/tb_sha_phase_scheduler.sv
// Scoreboard bench for sha_phase_scheduler with a reactive core model.
// Expected event timelines come from a per-run arithmetic model.
module tb_sha_phase_scheduler;

  localparam int NC = 4;
  localparam int NN = 8;
  localparam int TO = 80;
  localparam int NB = NN / NC;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [NC-1:0] core_done;
  logic [NC-1:0] core_start;
  logic [1:0]    phase;
  logic [15:0]   nonce_base;
  logic          hin_sel;
  logic          mid_capture;
  logic          result_we;
  logic          busy;
  logic          done;
  logic          error;

  sha_phase_scheduler #(
    .NUM_CORES(NC),
    .NUM_NONCES(NN),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .core_done(core_done),
    .core_start(core_start),
    .phase(phase),
    .nonce_base(nonce_base),
    .hin_sel(hin_sel),
    .mid_capture(mid_capture),
    .result_we(result_we),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int            cyc;
  int            n_chk = 0;
  int            n_pass = 0;
  logic [63:0]   expq[$];
  logic [NC-1:0] pend[int];

  // Core model configuration: response delay per phase/batch/core, 0 = silent
  int            d1;
  logic [NC-1:0] p1mask;
  int            d2[NB][NC];
  int            d3[NB][NC];
  bit            dup_en;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ev(input int c, input logic [NC-1:0] cs,
    input logic mid, input logic rwe, input logic dn, input logic [1:0] ph,
    input logic [15:0] nb, input logic hs, input logic bz, input logic er);
    return {4'h0, c, cs, mid, rwe, dn, ph, nb, hs, bz, er};
  endfunction

  function automatic logic [63:0] outs();
    return 64'({core_start, phase, nonce_base, hin_sel, mid_capture,
                result_we, busy, done, error});
  endfunction

  task automatic add_pend(input int c, input logic [NC-1:0] m);
    if (pend.exists(c)) pend[c] = pend[c] | m;
    else pend[c] = m;
  endtask

  // Longest response in a phase, or -1 when some core misses the watchdog.
  function automatic int phase_len(input int ph, input int b);
    int m;
    int d;
    m = 0;
    for (int j = 0; j < NC; j++) begin
      d = (ph == 2) ? d2[b][j] : d3[b][j];
      if (d == 0 || d > TO) return -1;
      if (d > m) m = d;
    end
    return m;
  endfunction

  task automatic model_run(input int s, output int fin, output bit err);
    int          g;
    int          m;
    logic [15:0] nb;
    logic [NC-1:0] ones;
    ones = '1;
    err = 1'b0;
    nb = '0;
    fin = 0;
    g = s + 1;
    expq.push_back(ev(g, 4'b0001, 0, 0, 0, 2'd1, 16'd0, 0, 1, 0));
    if (d1 == 0 || d1 > TO) begin
      err = 1'b1;
      fin = g + TO + 1;
    end else begin
      expq.push_back(ev(g + d1, '0, 1, 0, 0, 2'd1, 16'd0, 0, 1, 0));
      g = g + d1 + 1;
      for (int b = 0; b < NB; b++) begin
        nb = 16'(b * NC);
        expq.push_back(ev(g, ones, 0, 0, 0, 2'd2, nb, 1, 1, 0));
        m = phase_len(2, b);
        if (m < 0) begin
          err = 1'b1;
          fin = g + TO + 1;
          break;
        end
        g = g + m + 1;
        expq.push_back(ev(g, ones, 0, 0, 0, 2'd3, nb, 0, 1, 0));
        m = phase_len(3, b);
        if (m < 0) begin
          err = 1'b1;
          fin = g + TO + 1;
          break;
        end
        expq.push_back(ev(g + m, '0, 0, 1, 0, 2'd3, nb, 0, 1, 0));
        g = g + m + 1;
      end
      if (!err) fin = g;
    end
    expq.push_back(ev(fin, '0, 0, 0, 1, 2'd0, nb, 0, 0, err));
  endtask

  function automatic int rnd(input bit zeros);
    if (zeros && $urandom_range(19, 0) == 0) return 0;
    return int'($urandom_range(40, 1));
  endfunction

  task automatic set_all(input int d);
    d1 = d;
    p1mask = 4'b0001;
    dup_en = 1'b0;
    for (int b = 0; b < NB; b++)
      for (int j = 0; j < NC; j++) begin
        d2[b][j] = d;
        d3[b][j] = d;
      end
  endtask

  task automatic randomize_cfg(input bit zeros);
    d1 = rnd(zeros);
    p1mask = 4'b0001;
    dup_en = 1'b0;
    for (int b = 0; b < NB; b++)
      for (int j = 0; j < NC; j++) begin
        d2[b][j] = rnd(zeros);
        d3[b][j] = rnd(zeros);
      end
  endtask

  task automatic respond();
    int b;
    int d;
    logic [NC-1:0] m;
    b = int'(nonce_base) / NC;
    if (b >= NB) b = NB - 1;
    for (int j = 0; j < NC; j++) begin
      if (core_start[j]) begin
        m = '0;
        m[j] = 1'b1;
        d = 0;
        if (phase == 2'd1) begin
          d = d1;
          m = p1mask;
        end else if (phase == 2'd2) begin
          d = d2[b][j];
        end else if (phase == 2'd3) begin
          d = d3[b][j];
        end
        if (d > 0) add_pend(cyc + d, m);
      end
    end
    if (dup_en && phase == 2'd2 && b == 0) add_pend(cyc + 12, 4'b0010);
  endtask

  task automatic monitor_step();
    if (core_start != '0 || mid_capture || result_we || done) begin
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL event: got %h expected none",
          ev(cyc, core_start, mid_capture, result_we, done, phase,
             nonce_base, hin_sel, busy, error));
      end else begin
        check("event", ev(cyc, core_start, mid_capture, result_we, done,
              phase, nonce_base, hin_sel, busy, error), expq.pop_front());
      end
    end
  endtask

  always @(negedge clk) if (reset_n) monitor_step();
  always @(negedge clk) if (reset_n && core_start != '0) respond();

  initial begin
    cyc = 0;
    core_done = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (pend.exists(cyc)) begin
        core_done = pend[cyc];
        pend.delete(cyc);
      end else begin
        core_done = '0;
      end
    end
  end

  task automatic drain(input string name, input int lim);
    int n;
    n = 0;
    while (expq.size() != 0 && n < lim) begin
      tick();
      n++;
    end
    n_chk++;
    if (expq.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL %s_drain: got %0d events missing expected 0, next %h",
        name, expq.size(), expq[0]);
      expq.delete();
    end
  endtask

  task automatic idle_check(input string name, input bit err);
    repeat (3) tick();
    check({name, "_idle"}, 64'({busy, done, error}),
          64'({1'b0, 1'b0, err}));
  endtask

  task automatic do_run(input string name);
    int s;
    int fin;
    bit err;
    s = cyc;
    start = 1'b1;
    model_run(s, fin, err);
    tick();
    start = 1'b0;
    drain(name, fin - s + 20);
    idle_check(name, err);
  endtask

  initial begin
    int s;
    int c;
    int fin;
    int fin2;
    bit err;
    bit err2;
    reset_n = 1'b0;
    start = 1'b0;
    set_all(70);
    repeat (3) tick();
    check("reset_outs", outs(), 64'd0);
    reset_n = 1'b1;
    tick();

    set_all(70);
    do_run("basic");

    // Strays in IDLE/P1, done0 delivered as all ones, staggered P2
    randomize_cfg(1'b0);
    d1 = 3;
    p1mask = 4'b1111;
    d2[0] = '{5, 9, 9, 30};
    dup_en = 1'b1;
    c = cyc;
    add_pend(c + 1, 4'b1111);
    add_pend(c + 3, 4'b0100);
    add_pend(c + 4, 4'b1110);
    tick();
    tick();
    do_run("stagger");

    set_all(10);
    d3[0][3] = 0;
    do_run("timeout");

    randomize_cfg(1'b0);
    do_run("after_timeout");

    for (int i = 0; i < 5; i++) begin
      randomize_cfg(1'b1);
      do_run("random");
    end

    set_all(70);
    s = cyc;
    start = 1'b1;
    model_run(s, fin, err);
    tick();
    start = 1'b0;
    while (cyc < s + 82) tick();
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", outs(), 64'd0);
    expq.delete();
    pend.delete();
    repeat (3) begin
      tick();
      check("reset_hold", outs(), 64'd0);
    end
    reset_n = 1'b1;
    tick();
    randomize_cfg(1'b0);
    do_run("post_reset");

    randomize_cfg(1'b0);
    s = cyc;
    start = 1'b1;
    model_run(s, fin, err);
    model_run(fin + 1, fin2, err2);
    while (cyc < fin + 2) tick();
    start = 1'b0;
    drain("held", fin2 - cyc + 20);
    idle_check("held", err2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
